io_bus_master: RTL and testbench

//  CPU-side initiator for the external IO bus: turns single CPU load/store requests into
//  cs/rd/wr cycles on the IO device and returns read data on the device's rdy handshake.

---
 rtl/io_bus_master.sv | 149 ++++++++++++++
 tb/tb_io_bus_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_master.sv
// io_bus_master: CPU-side initiator for the external IO bus.
// Turns single CPU load/store requests into cs/rd/wr cycles on the IO device
// and returns read data on the device's rdy handshake. Also latches the
// device interrupt as a pending CPU interrupt and returns an ack pulse.
// Optional feature macro: IO_TIMEOUT_EN (READ aborts to ERROR after TIMEOUT
// cycles without io_rdy). Without it READ waits indefinitely and cpu_err is 0.
module io_bus_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ACK_CYCLES = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              cpu_busy,
  output logic              cpu_intr,
  input  logic              cpu_intr_ack,
  output logic [ADDR_W-1:0] io_address,
  output logic [DATA_W-1:0] io_out,
  input  logic [DATA_W-1:0] io_in,
  output logic              io_cs,
  output logic              io_rd,
  output logic              io_wr,
  input  logic              io_rdy,
  input  logic              io_intr,
  output logic              io_intr_ack
);

  localparam int ACK_W = $clog2(ACK_CYCLES + 1);

  // Both lengths must be at least one cycle for the pulse/timeout logic to work.
  if (ACK_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("io_bus_master: ACK_CYCLES and TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, state_nxt;

`ifdef IO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts cycles spent in READ; zero whenever outside READ, so it is
  // already cleared on the first READ cycle.
  always_ff @(posedge sys_clk) begin
    if (reset || state != S_READ) to_cnt <= '0;
    else                          to_cnt <= to_cnt + 1'b1;
  end
`endif

  // Next-state logic; io_rdy is checked before the timeout so a late
  // response on the final allowed cycle still completes normally.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cpu_req) state_nxt = cpu_we ? S_WRITE : S_READ;
      S_WRITE: state_nxt = S_DONE;
      S_READ: begin
        if (io_rdy) state_nxt = S_DONE;
`ifdef IO_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT - 1)) state_nxt = S_ERROR;
`endif
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERROR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus strobes registered from the next state, so every
  // output is a flop that tracks the state it belongs to.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state    <= S_IDLE;
      io_cs    <= 1'b0;
      io_rd    <= 1'b0;
      io_wr    <= 1'b0;
      cpu_busy <= 1'b0;
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      io_cs    <= (state_nxt == S_READ) || (state_nxt == S_WRITE);
      io_rd    <= (state_nxt == S_READ);
      io_wr    <= (state_nxt == S_WRITE);
      cpu_busy <= (state_nxt != S_IDLE);
      cpu_done <= (state_nxt == S_DONE) || (state_nxt == S_ERROR);
      cpu_err  <= (state_nxt == S_ERROR);
    end
  end

  // Request capture in IDLE and read-data capture on the rdy handshake;
  // cpu_rdata is left untouched by a timed-out read.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      io_address <= '0;
      io_out     <= '0;
      cpu_rdata  <= '0;
    end else begin
      if (state == S_IDLE && cpu_req) begin
        io_address <= cpu_addr;
        io_out     <= cpu_wdata;
      end
      if (state == S_READ && io_rdy) cpu_rdata <= io_in;
    end
  end

  logic             intr_q;
  logic             pending;
  logic [ACK_W-1:0] ack_cnt;
  logic             intr_rise;
  logic             ack_fire;

  assign intr_rise   = io_intr & ~intr_q;
  assign ack_fire    = cpu_intr_ack & pending;
  assign cpu_intr    = pending;
  assign io_intr_ack = (ack_cnt != '0);

  // Interrupt termination: a new edge wins over a same-cycle ack so it is
  // never lost; the ack pulse still goes out for the interrupt being cleared.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      intr_q  <= 1'b0;
      pending <= 1'b0;
      ack_cnt <= '0;
    end else begin
      intr_q <= io_intr;
      if (intr_rise)         pending <= 1'b1;
      else if (cpu_intr_ack) pending <= 1'b0;
      if (ack_fire)            ack_cnt <= ACK_W'(ACK_CYCLES);
      else if (ack_cnt != '0)  ack_cnt <= ack_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Self-checking bench for io_bus_master: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-timeline model of the bus and interrupt behaviour.
module tb_io_bus_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int ACK = 1;
  localparam int TO  = 16;
`ifdef IO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_done, cpu_err, cpu_busy, cpu_intr;
  logic          cpu_intr_ack = 1'b0;
  logic [AW-1:0] io_address;
  logic [DW-1:0] io_out;
  logic [DW-1:0] io_in = '0;
  logic          io_cs, io_rd, io_wr;
  logic          io_rdy = 1'b0, io_intr = 1'b0;
  logic          io_intr_ack;

  always #5 sys_clk = ~sys_clk;

  io_bus_master #(.ADDR_W(AW), .DATA_W(DW), .ACK_CYCLES(ACK), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .cpu_intr(cpu_intr), .cpu_intr_ack(cpu_intr_ack),
    .io_address(io_address), .io_out(io_out), .io_in(io_in),
    .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr), .io_rdy(io_rdy),
    .io_intr(io_intr), .io_intr_ack(io_intr_ack)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding transaction described by its age (cycles since the
  // accepting edge) and the age at which the completion pulse is shown.
  bit          m_active, m_we, m_err;
  int          m_age, m_end;
  logic [31:0] m_addr, m_wdata, m_rdata;
  bit          m_prev, m_pend;
  int          cyc = 0;
  int          last_fire = -1000;

  always @(posedge sys_clk) begin
    if (reset) begin
      m_active = 0; m_we = 0; m_err = 0; m_age = 0; m_end = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_prev = 0; m_pend = 0; last_fire = -1000;
    end else begin
      if (!m_active) begin
        if (cpu_req) begin
          m_active = 1; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
          m_age = 1; m_end = cpu_we ? 2 : 0; m_err = 0;
        end
      end else begin
        if (!m_we && m_end == 0) begin
          if (io_rdy) begin
            m_rdata = io_in; m_end = m_age + 1;
          end else if (TO_EN && m_age == TO) begin
            m_end = m_age + 1; m_err = 1;
          end
        end
        if (m_age == m_end) m_active = 0;
        else m_age++;
      end
      if (cpu_intr_ack && m_pend) last_fire = cyc;
      m_pend = (io_intr && !m_prev) || (m_pend && !cpu_intr_ack);
      m_prev = io_intr;
    end
    cyc++;
  end

  bit chk_on = 0;
  bit e_rd, e_wr, e_done, e_ack;

  always @(negedge sys_clk) begin
    if (chk_on) begin
      e_rd   = m_active && !m_we && (m_end == 0 || m_age < m_end);
      e_wr   = m_active && m_we && m_age == 1;
      e_done = m_active && m_age == m_end;
      e_ack  = (cyc - last_fire) >= 1 && (cyc - last_fire) <= ACK;
      chk("m_cs", io_cs, e_rd | e_wr);
      chk("m_rd", io_rd, e_rd);
      chk("m_wr", io_wr, e_wr);
      chk("m_busy", cpu_busy, m_active);
      chk("m_done", cpu_done, e_done);
      chk("m_err", cpu_err, e_done && m_err);
      chk("m_addr", io_address, m_addr);
      chk("m_out", io_out, m_wdata);
      chk("m_rdata", cpu_rdata, m_rdata);
      chk("m_intr", cpu_intr, m_pend);
      chk("m_intr_ack", io_intr_ack, e_ack);
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge sys_clk);
    chk_on = 1;
    #1 reset = 1'b0;
    @(negedge sys_clk);
    chk("rst_busy", cpu_busy, 1'b0);
    chk("rst_addr", io_address, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);

    // Write: strobes in cycle 1, done in cycle 2.
    step(); cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hA5A51234;
    step(); cpu_req = 0;
    @(negedge sys_clk);
    chk("wr_cs", io_cs, 1'b1); chk("wr_wr", io_wr, 1'b1);
    chk("wr_out", io_out, 32'hA5A51234); chk("wr_addr", io_address, 32'h10);
    chk("wr_done_c1", cpu_done, 1'b0);
    step(); @(negedge sys_clk);
    chk("wr_done", cpu_done, 1'b1); chk("wr_cs_c2", io_cs, 1'b0);
    step(); @(negedge sys_clk);
    chk("wr_idle_done", cpu_done, 1'b0); chk("wr_idle_busy", cpu_busy, 1'b0);

    // Read with rdy in the 4th READ cycle; cpu_req stays high (with other
    // attributes) throughout and must be ignored.
    step(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; io_rdy = 0; io_in = 32'hDEAD0000;
    step(); cpu_we = 1; cpu_addr = 32'h99; cpu_wdata = 32'h0BAD0BAD;
    @(negedge sys_clk);
    chk("rd_cs", io_cs, 1'b1); chk("rd_rd", io_rd, 1'b1); chk("rd_wr", io_wr, 1'b0);
    step(); step();
    @(negedge sys_clk);
    chk("rd_hold_wr", io_wr, 1'b0); chk("rd_hold_addr", io_address, 32'h10);
    chk("rd_hold_rdata", cpu_rdata, 32'h0); chk("rd_hold_busy", cpu_busy, 1'b1);
    step(); io_rdy = 1; io_in = 32'hA5A51234; cpu_req = 0;
    step(); io_rdy = 0; io_in = 32'h0;
    @(negedge sys_clk);
    chk("rd_done", cpu_done, 1'b1); chk("rd_data", cpu_rdata, 32'hA5A51234);
    chk("rd_err", cpu_err, 1'b0); chk("rd_cs_off", io_cs, 1'b0);
    step(); @(negedge sys_clk);
    chk("rd_done_1pulse", cpu_done, 1'b0); chk("rd_busy_off", cpu_busy, 1'b0);

    // Interrupt: edge -> pending, ack -> one-cycle io_intr_ack.
    step(); io_intr = 1;
    step(); @(negedge sys_clk);
    chk("int_pend", cpu_intr, 1'b1); chk("int_ack_idle", io_intr_ack, 1'b0);
    step(); cpu_intr_ack = 1;
    step(); cpu_intr_ack = 0;
    @(negedge sys_clk);
    chk("int_ack", io_intr_ack, 1'b1); chk("int_clr", cpu_intr, 1'b0);
    step(); @(negedge sys_clk);
    chk("int_ack_end", io_intr_ack, 1'b0);
    step(); cpu_intr_ack = 1;
    step(); cpu_intr_ack = 0;
    @(negedge sys_clk);
    chk("int_ack_nopend", io_intr_ack, 1'b0);
    io_intr = 0;

    // Reset in the middle of a READ aborts it without completion.
    step(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    step(); cpu_req = 0;
    step(); step(); reset = 1;
    step(); reset = 0;
    @(negedge sys_clk);
    chk("rst_rd_cs", io_cs, 1'b0); chk("rst_rd_rd", io_rd, 1'b0);
    chk("rst_rd_busy", cpu_busy, 1'b0); chk("rst_rd_done", cpu_done, 1'b0);
    chk("rst_rd_rdata", cpu_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(); @(negedge sys_clk);
      chk("rst_rd_nodone", cpu_done, 1'b0);
    end

    // Device that never answers.
    step(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
    step(); cpu_req = 0;
`ifdef IO_TIMEOUT_EN
    repeat (15) step();
    @(negedge sys_clk);
    chk("to_last_read_cs", io_cs, 1'b1); chk("to_last_read_done", cpu_done, 1'b0);
    step(); @(negedge sys_clk);
    chk("to_done", cpu_done, 1'b1); chk("to_err", cpu_err, 1'b1);
    chk("to_rdata_kept", cpu_rdata, 32'h0); chk("to_cs_off", io_cs, 1'b0);
    step();
`else
    repeat (100) step();
    @(negedge sys_clk);
    chk("nto_busy", cpu_busy, 1'b1); chk("nto_cs", io_cs, 1'b1);
    chk("nto_done", cpu_done, 1'b0); chk("nto_err", cpu_err, 1'b0);
    io_rdy = 1; io_in = 32'h12345678;
    step(); io_rdy = 0;
    @(negedge sys_clk);
    chk("nto_late_done", cpu_done, 1'b1); chk("nto_late_data", cpu_rdata, 32'h12345678);
    step();
`endif

    // Randomized traffic; the second half makes rdy rare to reach timeouts.
    for (int i = 0; i < 4000; i++) begin
      step();
      cpu_req      = ($urandom_range(0, 3) == 0);
      cpu_we       = $urandom_range(0, 1);
      cpu_addr     = $urandom;
      cpu_wdata    = $urandom;
      io_in        = $urandom;
      io_rdy       = (i < 2000) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 24) == 0);
      cpu_intr_ack = ($urandom_range(0, 5) == 0);
      reset        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 6) == 0) io_intr = ~io_intr;
    end
    step(); reset = 0; cpu_req = 0;
    repeat (3) step();
    @(negedge sys_clk);
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
